// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button sync/debounce plus IDLE/RUN/PAUSE/SPLIT mode FSM driving the stopwatch datapath
module stopwatch_ctrl #(
  parameter int unsigned DEB_CYCLES    = 20000,
  parameter int unsigned SPLIT_HOLD_MS = 3000,
  parameter int unsigned LAP_MAX       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       tick_1ms,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_capture,
  output logic       disp_freeze,
  output logic [3:0] lap_idx,
  output logic       lap_full,
  output logic [1:0] state
);
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = (SPLIT_HOLD_MS > 0) ? $clog2(SPLIT_HOLD_MS + 1) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, SPLIT} state_t;
  logic [1:0] btn;
  logic [1:0] press;
  assign btn = {btn_lap, btn_start};
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic s1_q, s2_q, deb_q, deb_d, prev_q, press_q, hit;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
      hit = (s2_q != deb_q) && (cnt_q == CW'(DEB_CYCLES - 1));
      cnt_d = ((s2_q != deb_q) && !hit) ? cnt_q + CW'(1) : '0;
      deb_d = deb_q ^ hit;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        deb_q   <= 1'b0;
        prev_q  <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q    <= btn[i];
        s2_q    <= s1_q;
        deb_q   <= deb_d;
        prev_q  <= deb_q;
        press_q <= deb_q & ~prev_q;
        cnt_q   <= cnt_d;
      end
    end
    assign press[i] = press_q;
  end
  state_t state_q, state_d;
  logic [3:0] lap_idx_q, lap_idx_d;
  logic [HW-1:0] hold_q, hold_d, hold_nx;
  logic cnt_en_q, cnt_clr_q, cnt_clr_d, lap_capture_q, lap_capture_d, disp_freeze_q, lap_full_q;
  logic start_ev, lap_ev, tick_on, timeout;
  always_comb begin
    start_ev = press[0];
    lap_ev = press[1] && !press[0];
    tick_on = (SPLIT_HOLD_MS != 0) && tick_1ms;
    hold_nx = hold_q + HW'(1);
    timeout = tick_on && (hold_nx == HW'(SPLIT_HOLD_MS));
    state_d = state_q;
    lap_idx_d = lap_idx_q;
    hold_d = '0;
    cnt_clr_d = 1'b0;
    lap_capture_d = 1'b0;
    case (state_q)
      IDLE: state_d = start_ev ? RUN : IDLE;
      RUN: begin
        if (start_ev) state_d = PAUSE;
        else if (lap_ev && !lap_full_q) begin
          state_d = SPLIT;
          lap_capture_d = 1'b1;
          lap_idx_d = lap_idx_q + 4'd1;
        end
      end
      PAUSE: begin
        if (start_ev) state_d = RUN;
        else if (lap_ev) begin
          state_d = IDLE;
          cnt_clr_d = 1'b1;
          lap_idx_d = '0;
        end
      end
      SPLIT: begin
        if (start_ev) state_d = PAUSE;
        else if (lap_ev && !lap_full_q) begin
          lap_capture_d = 1'b1;
          lap_idx_d = lap_idx_q + 4'd1;
        end else if (timeout) state_d = RUN;
        else hold_d = tick_on ? hold_nx : hold_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lap_idx_q     <= '0;
      hold_q        <= '0;
      cnt_en_q      <= 1'b0;
      cnt_clr_q     <= 1'b0;
      lap_capture_q <= 1'b0;
      disp_freeze_q <= 1'b0;
      lap_full_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lap_idx_q     <= lap_idx_d;
      hold_q        <= hold_d;
      cnt_en_q      <= (state_d == RUN) || (state_d == SPLIT);
      cnt_clr_q     <= cnt_clr_d;
      lap_capture_q <= lap_capture_d;
      disp_freeze_q <= state_d == SPLIT;
      lap_full_q    <= lap_idx_d == 4'(LAP_MAX);
    end
  end
  assign state       = state_q;
  assign lap_idx     = lap_idx_q;
  assign cnt_en      = cnt_en_q;
  assign cnt_clr     = cnt_clr_q;
  assign lap_capture = lap_capture_q;
  assign disp_freeze = disp_freeze_q;
  assign lap_full    = lap_full_q;
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the HH:MM:SS.mmm stopwatch datapath. It takes two raw push-buttons (START/STOP and LAP/RESET), synchronises and debounces them, and runs a four-state mode FSM. The FSM drives the datapath count-enable, the synchronous clear, the lap-capture strobe and the display-freeze select. The block sits between the board buttons and the counter/FND-scan datapath.

Parameters:
DEB_CYCLES, 20000, consecutive stable clk samples needed to accept a button level change (20 ms at 1 MHz)
SPLIT_HOLD_MS, 3000, tick_1ms pulses spent in SPLIT before automatic return to RUN; 0 disables the timeout
LAP_MAX, 9, maximum number of captured laps; lap_idx saturates at this value

Ports:
clk  input  1  system clock (1 MHz nominal)
rst  input  1  reset, asynchronous, active-high
btn_start  input  1  raw START/STOP button, active-high, asynchronous to clk
btn_lap  input  1  raw LAP/RESET button, active-high, asynchronous to clk
tick_1ms  input  1  one-clk pulse every 1 ms from the datapath prescaler
cnt_en  output  1  datapath count enable
cnt_clr  output  1  one-clk pulse that clears all time digits
lap_capture  output  1  one-clk pulse that latches the current time into the lap register
disp_freeze  output  1  1 = FND shows the lap register, 0 = FND shows the live time
lap_idx  output  4  number of laps captured since the last clear, 0..LAP_MAX
lap_full  output  1  high when lap_idx == LAP_MAX
state  output  2  current state: 0 IDLE, 1 RUN, 2 PAUSE, 3 SPLIT

Behaviour:
- Reset: clk and rst are as already decided (reset rst, asynchronous, active-high; clock clk). While rst is high, state=IDLE and every output is 0, including the synchroniser, debounce counters and hold counter. Reset mid-operation aborts immediately and does not generate a cnt_clr pulse.
- Input path, per button:
  - 2-FF synchroniser.
  - Debounce counter counts consecutive cycles in which the synced value differs from the debounced level. It resets to 0 on any agreement.
  - The debounced level toggles on the edge where the count reaches DEB_CYCLES.
  - A press event is the debounced rising edge, one cycle wide. Release events are ignored.
- Latency: with the raw input held high from the first sampling edge E0, the state/outputs update at edge E0+DEB_CYCLES+3. Glitches shorter than DEB_CYCLES cycles produce no event.
- All outputs are registered. cnt_en=1 in RUN and SPLIT. disp_freeze=1 only in SPLIT.
- FSM transitions. Priority: start event > lap event > hold timeout. At most one transition per cycle.
  - IDLE: start -> RUN. lap is ignored.
  - RUN: start -> PAUSE. lap with !lap_full -> SPLIT, pulse lap_capture, lap_idx+1, hold counter cleared. lap with lap_full is ignored.
  - SPLIT: start -> PAUSE (disp_freeze drops). lap with !lap_full -> stay in SPLIT, pulse lap_capture, lap_idx+1, hold counter restarted. Hold counter increments on tick_1ms. When it reaches SPLIT_HOLD_MS (and SPLIT_HOLD_MS != 0) -> RUN.
  - PAUSE: start -> RUN. lap -> IDLE, pulse cnt_clr, lap_idx=0.
- lap_capture and cnt_clr are asserted in the same cycle that the new state becomes visible. Never more than one cycle wide.
- lap_idx saturates at LAP_MAX. It never wraps.
- Hold counter width is ceil(log2(SPLIT_HOLD_MS+1)) bits. It is held at 0 outside SPLIT.
- Simultaneous start and lap events in the same cycle: only start acts. The lap event is discarded, not queued.
- tick_1ms in the same cycle as a lap in SPLIT: the lap restart wins and the hold counter is set to 0.

Test Plan:
All scenarios use DEB_CYCLES=4, SPLIT_HOLD_MS=5, LAP_MAX=3.
1. Reset, then btn_start high from edge E0 -> state=1 and cnt_en=1 exactly at E0+7. A 3-cycle btn_start glitch -> no state change.
2. RUN, press lap -> state=3, lap_capture for exactly 1 cycle, lap_idx=1, disp_freeze=1. Then 5 tick_1ms pulses -> state=1 and disp_freeze=0 on the edge after the 5th tick.
3. RUN, lap 3 times with ticks between presses (lap_idx 1,2,3; lap_full=1) -> a 4th lap gives no lap_capture, lap_idx stays 3, state unchanged.
4. SPLIT, press start -> state=2, cnt_en=0, disp_freeze=0. Then press lap -> state=0, cnt_clr for 1 cycle, lap_idx=0, lap_full=0.
5. btn_start and btn_lap raised on the same edge in RUN -> state=2, no lap_capture, lap_idx unchanged.
6. Assert rst in SPLIT with lap_idx=2 -> all outputs 0 and state=0 asynchronously, no cnt_clr pulse. After release, btn_start press -> RUN.
